// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: NOP encoding, fetch exception codes
// and the occupancy states used by the inter-stage registers.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch exception codes carried alongside each instruction
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;   // address error on instruction fetch
  localparam logic [4:0] EXC_IBE  = 5'd6;   // bus error on instruction fetch

  // Occupancy of a stage register: main slot empty, main full, main+skid full
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slot_state_t;

endpackage

// File: rtl/if_id_stage_reg.sv
// IF/ID stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and per-entry fetch exception code.
module if_id_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned          ADDR_W  = 32,
  parameter int unsigned          INSTR_W = 32,
  parameter int unsigned          EXC_W   = 5,
  parameter int unsigned          SKID    = 1,
  parameter logic [INSTR_W-1:0]   NOP     = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc4,
  output logic [ADDR_W-1:0]  out_pc8,
  output logic [EXC_W-1:0]   out_exc,
  output logic [1:0]         count
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [EXC_W-1:0]   exc;
  } entry_t;

  slot_state_t state_q;
  entry_t      main_q;
  entry_t      skid_q;
  entry_t      in_entry;
  logic        accept;
  logic        consume;

  // Handshake: with the skid buffer in_ready depends on registered state only
  always_comb begin
    out_valid = (state_q != EMPTY);
    if (SKID != 0) begin
      in_ready = (state_q != TWO) && !flush;
    end else begin
      in_ready = (!out_valid || out_ready) && !flush;
    end
    accept   = in_valid && in_ready;
    consume  = out_valid && out_ready;
    in_entry = '{instr: in_instr, pc: in_pc, exc: in_exc};
  end

  // Occupancy and slot contents; reset beats flush beats handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_q  <= in_entry;
          end else if (accept && SKID != 0) begin
            skid_q  <= in_entry;
            state_q <= TWO;
          end else if (consume) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the skid-to-main move can happen
          if (consume) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Output masking and PC increments derived from the main slot
  always_comb begin
    out_pc    = main_q.pc;
    out_pc4   = main_q.pc + ADDR_W'(4);
    out_pc8   = main_q.pc + ADDR_W'(8);
    out_instr = out_valid ? main_q.instr : NOP;
    out_exc   = out_valid ? main_q.exc : '0;
    case (state_q)
      EMPTY:   count = 2'd0;
      ONE:     count = 2'd1;
      default: count = 2'd2;
    endcase
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: SKID=1 and SKID=0 instances share stimulus and
// are each compared against a queue-based occupancy model every cycle.
module tb_if_id_stage_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  in_exc;

  logic        in_ready_s1, out_valid_s1, in_ready_s0, out_valid_s0;
  logic [31:0] out_instr_s1, out_pc_s1, out_pc4_s1, out_pc8_s1;
  logic [31:0] out_instr_s0, out_pc_s0, out_pc4_s0, out_pc8_s0;
  logic [4:0]  out_exc_s1, out_exc_s0;
  logic [1:0]  count_s1, count_s0;

  always #5 clk = ~clk;

  if_id_stage_reg #(.ADDR_W(32), .INSTR_W(32), .EXC_W(5), .SKID(1), .NOP(32'h0)) dut_s1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s1),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
    .out_valid(out_valid_s1), .out_ready(out_ready),
    .out_instr(out_instr_s1), .out_pc(out_pc_s1), .out_pc4(out_pc4_s1),
    .out_pc8(out_pc8_s1), .out_exc(out_exc_s1), .count(count_s1)
  );

  if_id_stage_reg #(.ADDR_W(32), .INSTR_W(32), .EXC_W(5), .SKID(0), .NOP(32'h0)) dut_s0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s0),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
    .out_valid(out_valid_s0), .out_ready(out_ready),
    .out_instr(out_instr_s0), .out_pc(out_pc_s0), .out_pc4(out_pc4_s0),
    .out_pc8(out_pc8_s0), .out_exc(out_exc_s0), .count(count_s0)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
  } ent_t;

  // Model: k=1 is the skid instance (capacity 2), k=0 the plain one (capacity 1)
  ent_t        mq [0:1][$];
  logic [31:0] last_pc [0:1];

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int k);
    if (flush) return 1'b0;
    if (k == 1) return mq[k].size() < 2;
    return (mq[k].size() == 0) || out_ready;
  endfunction

  // Compare every output of both instances against the model
  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic        ov, ir;
      logic [31:0] oi, op, op4, op8, e_instr, e_pc;
      logic [4:0]  oe, e_exc;
      logic [1:0]  oc;
      bit          e_valid;
      if (k == 1) begin
        ov = out_valid_s1; ir = in_ready_s1; oi = out_instr_s1; op = out_pc_s1;
        op4 = out_pc4_s1; op8 = out_pc8_s1; oe = out_exc_s1; oc = count_s1;
      end else begin
        ov = out_valid_s0; ir = in_ready_s0; oi = out_instr_s0; op = out_pc_s0;
        op4 = out_pc4_s0; op8 = out_pc8_s0; oe = out_exc_s0; oc = count_s0;
      end
      e_valid = mq[k].size() > 0;
      e_instr = e_valid ? mq[k][0].instr : NOP_INSTR;
      e_exc   = e_valid ? mq[k][0].exc : EXC_NONE;
      e_pc    = e_valid ? mq[k][0].pc : last_pc[k];
      chk($sformatf("s%0d out_valid", k), {31'b0, ov}, {31'b0, e_valid});
      chk($sformatf("s%0d in_ready", k), {31'b0, ir}, {31'b0, exp_ready(k)});
      chk($sformatf("s%0d out_instr", k), oi, e_instr);
      chk($sformatf("s%0d out_pc", k), op, e_pc);
      chk($sformatf("s%0d out_pc4", k), op4, e_pc + 32'd4);
      chk($sformatf("s%0d out_pc8", k), op8, e_pc + 32'd8);
      chk($sformatf("s%0d out_exc", k), {27'b0, oe}, {27'b0, e_exc});
      chk($sformatf("s%0d count", k), {30'b0, oc}, mq[k].size());
    end
  endtask

  // Advance one clock and update the model with what the DUT should have done
  task automatic tick();
    bit   acc [0:1];
    ent_t e;
    for (int k = 0; k < 2; k++) acc[k] = in_valid && exp_ready(k);
    e = '{instr: in_instr, pc: in_pc, exc: in_exc};
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mq[k].delete();
        last_pc[k] = 32'h0;
      end else if (flush) begin
        mq[k].delete();
      end else begin
        if (mq[k].size() > 0 && out_ready) void'(mq[k].pop_front());
        if (acc[k]) mq[k].push_back(e);
      end
      if (mq[k].size() > 0) last_pc[k] = mq[k][0].pc;
    end
    #1;
  endtask

  task automatic cycle(input bit v, input logic [31:0] pc, input logic [4:0] exc,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = {pc[15:0], ~pc[15:0]};
    in_exc    = exc;
    out_ready = ordy;
    flush     = fl;
    reset     = 1'b0;
    #2;
    compare_all();
    tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_exc = '0;
    last_pc[0] = '0; last_pc[1] = '0;
    tick();
    tick();
    reset = 1'b0;
    #2;
    compare_all();
    chk("reset out_pc4", out_pc4_s1, 32'd4);
    chk("reset out_pc8", out_pc8_s1, 32'd8);
    chk("reset in_ready", {31'b0, in_ready_s1}, 32'd1);
    chk("reset count", {30'b0, count_s1}, 32'd0);

    // Streaming with out_ready held high
    cycle(1, 32'h3000, 0, 1, 0);
    chk("stream pc0", out_pc_s1, 32'h3000);
    cycle(1, 32'h3004, 0, 1, 0);
    chk("stream pc1", out_pc_s1, 32'h3004);
    cycle(1, 32'h3008, 0, 1, 0);
    chk("stream pc2", out_pc_s1, 32'h3008);
    chk("stream pc8", out_pc8_s1, 32'h3010);
    chk("stream count", {30'b0, count_s1}, 32'd1);
    cycle(0, 0, 0, 1, 0);

    // Stall: three offers with out_ready low, then release
    cycle(1, 32'h3000, 0, 0, 0);
    chk("stall count1", {30'b0, count_s1}, 32'd1);
    cycle(1, 32'h3004, 0, 0, 0);
    chk("stall count2", {30'b0, count_s1}, 32'd2);
    chk("stall in_ready", {31'b0, in_ready_s1}, 32'd0);
    cycle(1, 32'h3008, 0, 0, 0);
    chk("stall held", out_pc_s1, 32'h3000);
    cycle(0, 0, 0, 1, 0);
    chk("release pc", out_pc_s1, 32'h3004);
    cycle(0, 0, 0, 1, 0);
    chk("release empty", {30'b0, count_s1}, 32'd0);

    // Flush while full
    cycle(1, 32'h4000, 0, 0, 0);
    cycle(1, 32'h4004, 0, 0, 0);
    cycle(1, 32'h4008, 0, 0, 1);
    chk("flush count", {30'b0, count_s1}, 32'd0);
    chk("flush instr", out_instr_s1, 32'h0);
    cycle(0, 0, 0, 0, 0);
    chk("flush ready after", {31'b0, in_ready_s1}, 32'd1);

    // Plain register: full with decode stalled, then replace-in-place
    cycle(1, 32'h5000, 0, 0, 0);
    cycle(1, 32'h5004, 0, 0, 0);
    chk("s0 full in_ready", {31'b0, in_ready_s0}, 32'd0);
    cycle(1, 32'h5008, 0, 1, 0);
    chk("s0 replace pc", out_pc_s0, 32'h5008);
    chk("s0 replace count", {30'b0, count_s0}, 32'd1);
    cycle(0, 0, 0, 1, 1);

    // PC wrap with a fetch address error
    cycle(1, 32'hFFFF_FFFC, EXC_ADEL, 1, 0);
    chk("wrap pc4", out_pc4_s1, 32'h0);
    chk("wrap pc8", out_pc8_s1, 32'h4);
    chk("wrap exc", {27'b0, out_exc_s1}, 32'd4);
    cycle(0, 0, 0, 1, 0);
    chk("wrap exc cleared", {27'b0, out_exc_s1}, 32'd0);
    chk("wrap pc held", out_pc_s1, 32'hFFFF_FFFC);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(4, 0) < 3);
      flush     = ($urandom_range(19, 0) == 0);
      reset     = ($urandom_range(99, 0) == 0);
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      in_instr  = $urandom();
      in_exc    = ($urandom_range(7, 0) == 0) ? 5'($urandom_range(31, 1)) : EXC_NONE;
      #2;
      compare_all();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
